// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared types and helpers for the parametrised UART transceiver.
//   - tx_state_t / rx_state_t : FSM state encodings for the two directions.
//   - uart_cfg_t              : frame format captured at the start of a frame.
//   - parity_calc()           : parity over the low n bits of a byte.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic parity_en;
        logic parity_odd;
        logic stop2;
    } uart_cfg_t;

    // XOR of data[n-1:0], inverted for odd parity so that the data bits plus
    // the parity bit always contain an odd number of ones.
    function automatic logic parity_calc(input logic [7:0] data,
                                         input int         n,
                                         input logic       odd);
        logic p;
        p = odd;
        for (int i = 0; i < 8; i++) begin
            if (i < n) begin
                p = p ^ data[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_xcvr_if.sv
// -----------------------------------------------------------------------------
// uart_xcvr_if
//   Client-side bundle of the UART transceiver.
//   TX : tx_valid / tx_data (client -> xcvr), tx_ready (xcvr -> client).
//   RX : rx_valid pulse with rx_data and the error flags (xcvr -> client).
//   Modports: master = byte-stream client, slave = uart_xcvr.
// -----------------------------------------------------------------------------
interface uart_xcvr_if;

    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_break;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready,
        input  rx_valid,
        input  rx_data,
        input  rx_parity_err,
        input  rx_frame_err,
        input  rx_break
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready,
        output rx_valid,
        output rx_data,
        output rx_parity_err,
        output rx_frame_err,
        output rx_break
    );

endinterface

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
//   Oversampling tick generator: one-cycle tick every DIV clocks.
//   Ports:
//     clk     in  system clock
//     reset_n in  asynchronous active-low reset
//     clear   in  restart the divider; no tick is issued while clear is high
//     tick    out one-cycle pulse every DIV clocks
// -----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // After a clear the first tick lands DIV clocks later, so a bit that starts
    // on the cycle after the clear lasts exactly DIV*OVERSAMPLE clocks.
    assign tick = (cnt_q == LAST) && !clear;

endmodule

// File: rtl/uart_xcvr.sv
// -----------------------------------------------------------------------------
// uart_xcvr
//   Full-duplex UART: valid/ready transmitter and 16x-oversampled receiver with
//   runtime parity / stop-bit selection and parity, framing and break detection.
//   Parameters: CLK_FREQ, BAUD, OVERSAMPLE (even, >= 8), DATA_BITS (5..8).
//   Ports:
//     clk, reset_n            clock, asynchronous active-low reset
//     cfg_parity_en/_odd      parity present / odd parity
//     cfg_stop2               two stop bits on TX
//     cfg_loopback            (only with UART_LOOPBACK_EN) RX listens to TX,
//                             tx_serial pin held at 1
//     bus (uart_xcvr_if.slave) tx_valid/tx_data/tx_ready,
//                             rx_valid/rx_data/rx_parity_err/rx_frame_err/rx_break
//     tx_serial               serial out, idles high
//     rx_serial               serial in, asynchronous to clk
//   Optional feature macro: UART_LOOPBACK_EN.
// -----------------------------------------------------------------------------
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  cfg_parity_en,
    input  logic  cfg_parity_odd,
    input  logic  cfg_stop2,
`ifdef UART_LOOPBACK_EN
    input  logic  cfg_loopback,
`endif
    uart_xcvr_if.slave bus,
    output logic  tx_serial,
    input  logic  rx_serial
);

    localparam int             DIV       = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int             OSW       = $clog2(OVERSAMPLE);
    localparam logic [OSW-1:0] OS_LAST   = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] HALF_LAST = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [2:0]     BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic [7:0]     DATA_MASK = 8'((1 << DATA_BITS) - 1);

    generate
        if (DIV < 1) begin : g_bad_div
            $error("uart_xcvr: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 1");
        end
        if ((OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_os
            $error("uart_xcvr: OVERSAMPLE must be even and at least 8");
        end
        if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_bad_bits
            $error("uart_xcvr: DATA_BITS must be in 5..8");
        end
    endgenerate

    // ------------------------------------------------------------------ TX --
    logic           tx_tick, tx_start, tx_bit_done;
    tx_state_t      tx_state_q, tx_state_d;
    logic [OSW-1:0] tx_tick_cnt_q, tx_tick_cnt_d;
    logic [2:0]     tx_bit_cnt_q, tx_bit_cnt_d;
    logic [7:0]     tx_data_q, tx_data_d;
    uart_cfg_t      tx_cfg_q, tx_cfg_d;
    logic           tx_line_q, tx_line_d;
    logic           tx_ready_q, tx_ready_d;

    // tx_ready is only high in TX_IDLE, so this is the handshake cycle.
    assign tx_start = bus.tx_valid && tx_ready_q;

    uart_baud_tick #(.DIV(DIV)) u_tx_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (tx_start),
        .tick    (tx_tick)
    );

    assign tx_bit_done = tx_tick && (tx_tick_cnt_q == OS_LAST);

    always_comb begin
        tx_state_d    = tx_state_q;
        tx_tick_cnt_d = tx_tick_cnt_q;
        tx_bit_cnt_d  = tx_bit_cnt_q;
        tx_data_d     = tx_data_q;
        tx_cfg_d      = tx_cfg_q;
        tx_line_d     = tx_line_q;
        tx_ready_d    = tx_ready_q;

        if ((tx_state_q != TX_IDLE) && tx_tick) begin
            tx_tick_cnt_d = (tx_tick_cnt_q == OS_LAST) ? '0 : tx_tick_cnt_q + OSW'(1);
        end

        case (tx_state_q)
            TX_IDLE: begin
                if (tx_start) begin
                    tx_state_d    = TX_START;
                    tx_data_d     = bus.tx_data & DATA_MASK;
                    tx_cfg_d      = '{parity_en:  cfg_parity_en,
                                      parity_odd: cfg_parity_odd,
                                      stop2:      cfg_stop2};
                    tx_tick_cnt_d = '0;
                    tx_bit_cnt_d  = '0;
                    tx_line_d     = 1'b0;
                    tx_ready_d    = 1'b0;
                end
            end
            TX_START: begin
                if (tx_bit_done) begin
                    tx_state_d = TX_DATA;
                    tx_line_d  = tx_data_q[0];
                end
            end
            TX_DATA: begin
                if (tx_bit_done) begin
                    if (tx_bit_cnt_q == BIT_LAST) begin
                        tx_bit_cnt_d = '0;
                        if (tx_cfg_q.parity_en) begin
                            tx_state_d = TX_PARITY;
                            tx_line_d  = parity_calc(tx_data_q, DATA_BITS, tx_cfg_q.parity_odd);
                        end else begin
                            tx_state_d = TX_STOP;
                            tx_line_d  = 1'b1;
                        end
                    end else begin
                        tx_bit_cnt_d = tx_bit_cnt_q + 3'd1;
                        tx_line_d    = tx_data_q[tx_bit_cnt_q + 3'd1];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_done) begin
                    tx_state_d   = TX_STOP;
                    tx_bit_cnt_d = '0;
                    tx_line_d    = 1'b1;
                end
            end
            TX_STOP: begin
                // tx_bit_cnt counts stop bits here: 0 = first, 1 = second.
                if (tx_bit_done) begin
                    if (tx_cfg_q.stop2 && (tx_bit_cnt_q == 3'd0)) begin
                        tx_bit_cnt_d = 3'd1;
                    end else begin
                        tx_state_d = TX_IDLE;
                        tx_ready_d = 1'b1;
                        tx_line_d  = 1'b1;
                    end
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_ready_d = 1'b1;
                tx_line_d  = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------ RX --
    logic           rx_in, rx_tick, rx_line, rx_sample;
    logic           rx_sync1_q, rx_sync1_d, rx_sync2_q, rx_sync2_d;
    rx_state_t      rx_state_q, rx_state_d;
    logic [OSW-1:0] rx_tick_cnt_q, rx_tick_cnt_d;
    logic [2:0]     rx_bit_cnt_q, rx_bit_cnt_d;
    logic [7:0]     rx_shift_q, rx_shift_d;
    logic           rx_par_en_q, rx_par_en_d;
    logic           rx_par_odd_q, rx_par_odd_d;
    logic           rx_par_bit_q, rx_par_bit_d;
    logic           rx_valid_q, rx_valid_d;
    logic [7:0]     rx_data_q, rx_data_d;
    logic           rx_perr_q, rx_perr_d;
    logic           rx_ferr_q, rx_ferr_d;
    logic           rx_brk_q, rx_brk_d;

`ifdef UART_LOOPBACK_EN
    logic lb_sel_q, lb_sel_d;

    // Switching the RX source mid-frame would corrupt it, so the select only
    // follows cfg_loopback while the receiver is idle.
    assign lb_sel_d  = (rx_state_q == RX_IDLE) ? cfg_loopback : lb_sel_q;
    assign rx_in     = lb_sel_q ? tx_line_q : rx_serial;
    assign tx_serial = cfg_loopback ? 1'b1 : tx_line_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lb_sel_q <= 1'b0;
        end else begin
            lb_sel_q <= lb_sel_d;
        end
    end
`else
    assign rx_in     = rx_serial;
    assign tx_serial = tx_line_q;
`endif

    uart_baud_tick #(.DIV(DIV)) u_rx_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (1'b0),
        .tick    (rx_tick)
    );

    assign rx_sync1_d = rx_in;
    assign rx_sync2_d = rx_sync1_q;
    assign rx_line    = rx_sync2_q;
    // Bit-centre sample point for DATA/PARITY/STOP: OVERSAMPLE ticks after the
    // previous sample.
    assign rx_sample  = rx_tick && (rx_tick_cnt_q == OS_LAST);

    always_comb begin
        rx_state_d    = rx_state_q;
        rx_tick_cnt_d = rx_tick_cnt_q;
        rx_bit_cnt_d  = rx_bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        rx_par_en_d   = rx_par_en_q;
        rx_par_odd_d  = rx_par_odd_q;
        rx_par_bit_d  = rx_par_bit_q;
        rx_valid_d    = 1'b0;
        rx_data_d     = rx_data_q;
        rx_perr_d     = rx_perr_q;
        rx_ferr_d     = rx_ferr_q;
        rx_brk_d      = rx_brk_q;

        if ((rx_state_q != RX_IDLE) && (rx_state_q != RX_START) && rx_tick) begin
            rx_tick_cnt_d = (rx_tick_cnt_q == OS_LAST) ? '0 : rx_tick_cnt_q + OSW'(1);
        end

        case (rx_state_q)
            RX_IDLE: begin
                if (rx_tick && !rx_line) begin
                    rx_state_d    = RX_START;
                    rx_tick_cnt_d = '0;
                end
            end
            RX_START: begin
                if (rx_tick) begin
                    if (rx_tick_cnt_q == HALF_LAST) begin
                        rx_tick_cnt_d = '0;
                        if (rx_line) begin
                            // Line went back high before mid-bit: a glitch.
                            rx_state_d = RX_IDLE;
                        end else begin
                            rx_state_d   = RX_DATA;
                            rx_bit_cnt_d = '0;
                            rx_shift_d   = '0;
                            rx_par_bit_d = 1'b0;
                            rx_par_en_d  = cfg_parity_en;
                            rx_par_odd_d = cfg_parity_odd;
                        end
                    end else begin
                        rx_tick_cnt_d = rx_tick_cnt_q + OSW'(1);
                    end
                end
            end
            RX_DATA: begin
                if (rx_sample) begin
                    rx_shift_d[rx_bit_cnt_q] = rx_line;
                    if (rx_bit_cnt_q == BIT_LAST) begin
                        rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_cnt_d = rx_bit_cnt_q + 3'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_sample) begin
                    rx_par_bit_d = rx_line;
                    rx_state_d   = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_sample) begin
                    rx_state_d = RX_IDLE;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_shift_q;
                    rx_perr_d  = rx_par_en_q &&
                                 (parity_calc(rx_shift_q, DATA_BITS, rx_par_odd_q) != rx_par_bit_q);
                    rx_ferr_d  = !rx_line;
                    // rx_par_bit is cleared at frame start, so it is 0 when no
                    // parity bit was received.
                    rx_brk_d   = !rx_line && (rx_shift_q == 8'h00) && !rx_par_bit_q;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------- registers --
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q    <= TX_IDLE;
            tx_tick_cnt_q <= '0;
            tx_bit_cnt_q  <= '0;
            tx_data_q     <= '0;
            tx_cfg_q      <= '0;
            tx_line_q     <= 1'b1;
            tx_ready_q    <= 1'b1;
            rx_sync1_q    <= 1'b1;
            rx_sync2_q    <= 1'b1;
            rx_state_q    <= RX_IDLE;
            rx_tick_cnt_q <= '0;
            rx_bit_cnt_q  <= '0;
            rx_shift_q    <= '0;
            rx_par_en_q   <= 1'b0;
            rx_par_odd_q  <= 1'b0;
            rx_par_bit_q  <= 1'b0;
            rx_valid_q    <= 1'b0;
            rx_data_q     <= '0;
            rx_perr_q     <= 1'b0;
            rx_ferr_q     <= 1'b0;
            rx_brk_q      <= 1'b0;
        end else begin
            tx_state_q    <= tx_state_d;
            tx_tick_cnt_q <= tx_tick_cnt_d;
            tx_bit_cnt_q  <= tx_bit_cnt_d;
            tx_data_q     <= tx_data_d;
            tx_cfg_q      <= tx_cfg_d;
            tx_line_q     <= tx_line_d;
            tx_ready_q    <= tx_ready_d;
            rx_sync1_q    <= rx_sync1_d;
            rx_sync2_q    <= rx_sync2_d;
            rx_state_q    <= rx_state_d;
            rx_tick_cnt_q <= rx_tick_cnt_d;
            rx_bit_cnt_q  <= rx_bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            rx_par_en_q   <= rx_par_en_d;
            rx_par_odd_q  <= rx_par_odd_d;
            rx_par_bit_q  <= rx_par_bit_d;
            rx_valid_q    <= rx_valid_d;
            rx_data_q     <= rx_data_d;
            rx_perr_q     <= rx_perr_d;
            rx_ferr_q     <= rx_ferr_d;
            rx_brk_q      <= rx_brk_d;
        end
    end

    assign bus.tx_ready      = tx_ready_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.rx_data       = rx_data_q;
    assign bus.rx_parity_err = rx_perr_q;
    assign bus.rx_frame_err  = rx_ferr_q;
    assign bus.rx_break      = rx_brk_q;

endmodule

// File: tb/tb_uart_xcvr.sv
// -----------------------------------------------------------------------------
// tb_uart_xcvr
//   Self-checking bench for uart_xcvr at 16 clocks per bit (DIV = 1).
//   RX frames come from a table of {stimulus, expected flags}; expected records
//   are queued as each frame is driven and compared when rx_valid arrives.
//   TX frames are captured bit by bit and compared to frames built here.
// -----------------------------------------------------------------------------
module tb_uart_xcvr;

    localparam int CLK_FREQ   = 1_600_000;
    localparam int BAUD       = 100_000;
    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int BIT_CLKS   = 16;
    localparam int NSAMP      = 240;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } rx_rec_t;

    typedef struct {
        logic [7:0] data;
        bit         pen;
        bit         podd;
        bit         bad_par;
        bit         stop_val;
        bit         e_perr;
        bit         e_ferr;
        bit         e_brk;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic cfg_parity_en, cfg_parity_odd, cfg_stop2;
    logic tx_serial, rx_serial;
    logic rx_drv, loop_en;

    assign rx_serial = loop_en ? tx_serial : rx_drv;

    uart_xcvr_if bus_if ();

    uart_xcvr #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE),
        .DATA_BITS  (DATA_BITS)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
`ifdef UART_LOOPBACK_EN
        .cfg_loopback   (1'b0),
`endif
        .bus            (bus_if),
        .tx_serial      (tx_serial),
        .rx_serial      (rx_serial)
    );

    int      n_vec  = 0;
    int      n_fail = 0;
    int      rx_cnt = 0;
    rx_rec_t exp_q[$];
    rx_rec_t obs_q[$];
    logic    tx_samp [0:NSAMP-1];
    vec_t    vecs [0:7];

    // Monitor: every rx_valid pulse is recorded for the scoreboard.
    always @(negedge clk) begin
        if (reset_n && bus_if.rx_valid) begin
            rx_cnt++;
            obs_q.push_back('{data: bus_if.rx_data, perr: bus_if.rx_parity_err,
                              ferr: bus_if.rx_frame_err, brk: bus_if.rx_break});
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation still running after 60000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Bit-bang one frame on rx_drv, LSB first, then 2 bit-times of idle.
    task automatic drive_rx_frame(input logic [7:0] d, input bit pen, input bit podd,
                                  input bit bad_par, input bit stop_val);
        logic pbit;
        pbit = (^d) ^ podd ^ bad_par;
        @(posedge clk);
        rx_drv = 1'b0;
        repeat (BIT_CLKS) @(posedge clk);
        for (int i = 0; i < DATA_BITS; i++) begin
            rx_drv = d[i];
            repeat (BIT_CLKS) @(posedge clk);
        end
        if (pen) begin
            rx_drv = pbit;
            repeat (BIT_CLKS) @(posedge clk);
        end
        rx_drv = stop_val;
        repeat (BIT_CLKS) @(posedge clk);
        rx_drv = 1'b1;
        repeat (2 * BIT_CLKS) @(posedge clk);
    endtask

    // Pop one observed and one expected record and compare field by field.
    task automatic expect_rx(input string name);
        rx_rec_t e, o;
        int      waited;
        waited = 0;
        while ((obs_q.size() == 0) && (waited < 400)) begin
            @(posedge clk);
            waited++;
        end
        if (obs_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: no rx_valid within 400 cycles, expected one", name);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: rx_valid with no expected frame queued", name);
            void'(obs_q.pop_front());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({name, " rx_data"},       32'(o.data), 32'(e.data));
            check({name, " rx_parity_err"}, 32'(o.perr), 32'(e.perr));
            check({name, " rx_frame_err"},  32'(o.ferr), 32'(e.ferr));
            check({name, " rx_break"},      32'(o.brk),  32'(e.brk));
        end
    endtask

    // Handshake one byte, then sample tx_serial once per clock starting right
    // after the transfer edge; ready_low counts clocks until tx_ready returns.
    task automatic tx_send(input logic [7:0] d, output int ready_low);
        int waited;
        bit done;
        @(negedge clk);
        waited = 0;
        while (!bus_if.tx_ready && (waited < 1000)) begin
            @(negedge clk);
            waited++;
        end
        if (!bus_if.tx_ready) check("tx_ready before send", 32'(bus_if.tx_ready), 32'd1);
        bus_if.tx_data  = d;
        bus_if.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.tx_valid = 1'b0;
        ready_low = 0;
        done      = 1'b0;
        for (int k = 0; k < NSAMP; k++) begin
            tx_samp[k] = tx_serial;
            if (!done) begin
                if (bus_if.tx_ready) done = 1'b1;
                else ready_low++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] frame_bits(input int nbits);
        logic [15:0] f;
        f = '0;
        for (int j = 0; j < nbits; j++) f[j] = tx_samp[16 * j + 8];
        return f;
    endfunction

    initial begin
        int       ready_low;
        int       cnt0;
        logic [7:0] par;

        vecs[0] = '{8'h81, 1, 0, 1, 1, 1, 0, 0};
        vecs[1] = '{8'h00, 0, 0, 0, 0, 0, 1, 1};
        vecs[2] = '{8'h55, 0, 0, 0, 0, 0, 1, 0};
        vecs[3] = '{8'h7E, 1, 1, 0, 1, 0, 0, 0};
        vecs[4] = '{8'h00, 1, 0, 0, 0, 0, 1, 1};
        vecs[5] = '{8'h00, 1, 1, 0, 0, 0, 1, 0};
        vecs[6] = '{8'hFF, 1, 0, 1, 0, 1, 1, 0};
        vecs[7] = '{8'hC3, 0, 0, 0, 1, 0, 0, 0};

        reset_n         = 1'b0;
        cfg_parity_en   = 1'b0;
        cfg_parity_odd  = 1'b0;
        cfg_stop2       = 1'b0;
        rx_drv          = 1'b1;
        loop_en         = 1'b0;
        bus_if.tx_valid = 1'b0;
        bus_if.tx_data  = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset tx_serial", 32'(tx_serial), 32'd1);
        check("reset tx_ready",  32'(bus_if.tx_ready), 32'd1);
        check("reset rx_valid",  32'(bus_if.rx_valid), 32'd0);
        check("reset rx_data",   32'(bus_if.rx_data), 32'd0);
        check("reset flags",     32'({bus_if.rx_parity_err, bus_if.rx_frame_err, bus_if.rx_break}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);

        // 8N1 transmit of 0xA5
        tx_send(8'hA5, ready_low);
        check("tx A5 frame",        32'(frame_bits(10)), 32'({1'b1, 8'hA5, 1'b0}));
        check("tx A5 ready low",    32'(ready_low), 32'd160);
        check("tx A5 start first",  32'(tx_samp[0]),  32'd0);
        check("tx A5 start last",   32'(tx_samp[15]), 32'd0);
        check("tx A5 bit0 first",   32'(tx_samp[16]), 32'd1);
        check("tx A5 idle after",   32'(tx_samp[160]), 32'd1);

        // Loopback 8E2 of 0x3C
        cfg_parity_en  = 1'b1;
        cfg_parity_odd = 1'b0;
        cfg_stop2      = 1'b1;
        loop_en        = 1'b1;
        cnt0           = rx_cnt;
        par            = 8'h3C;
        exp_q.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
        tx_send(8'h3C, ready_low);
        check("tx 3C 8E2 frame",     32'(frame_bits(12)), 32'({2'b11, ^par, 8'h3C, 1'b0}));
        check("tx 3C 8E2 ready low", 32'(ready_low), 32'd192);
        expect_rx("loop 3C");
        repeat (40) @(posedge clk);
        check("loop 3C rx_valid count", 32'(rx_cnt - cnt0), 32'd1);
        loop_en = 1'b0;

        // Table of received frames
        for (int v = 0; v < 8; v++) begin
            cfg_parity_en  = vecs[v].pen;
            cfg_parity_odd = vecs[v].podd;
            cfg_stop2      = 1'b0;
            cnt0 = rx_cnt;
            exp_q.push_back('{data: vecs[v].data, perr: vecs[v].e_perr,
                              ferr: vecs[v].e_ferr, brk: vecs[v].e_brk});
            drive_rx_frame(vecs[v].data, vecs[v].pen, vecs[v].podd,
                           vecs[v].bad_par, vecs[v].stop_val);
            expect_rx($sformatf("vec%0d", v));
            check($sformatf("vec%0d rx_valid count", v), 32'(rx_cnt - cnt0), 32'd1);
        end

        // Start-bit glitch of 4 clocks, then a clean 0x42
        cfg_parity_en = 1'b0;
        cnt0 = rx_cnt;
        @(posedge clk);
        rx_drv = 1'b0;
        repeat (4) @(posedge clk);
        rx_drv = 1'b1;
        repeat (40) @(posedge clk);
        check("glitch rx_valid count", 32'(rx_cnt - cnt0), 32'd0);
        exp_q.push_back('{data: 8'h42, perr: 1'b0, ferr: 1'b0, brk: 1'b0});
        drive_rx_frame(8'h42, 0, 0, 0, 1);
        expect_rx("after glitch 42");

        // Asynchronous reset 50 clocks into a TX frame
        cfg_parity_en = 1'b0;
        cfg_stop2     = 1'b0;
        cnt0 = rx_cnt;
        @(negedge clk);
        bus_if.tx_data  = 8'h00;
        bus_if.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.tx_valid = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check("pre-reset tx_serial", 32'(tx_serial), 32'd0);
        check("pre-reset tx_ready",  32'(bus_if.tx_ready), 32'd0);
        #1;
        reset_n = 1'b0;
        #1;
        check("async reset tx_serial", 32'(tx_serial), 32'd1);
        check("async reset tx_ready",  32'(bus_if.tx_ready), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tx_send(8'h11, ready_low);
        check("tx 11 frame",     32'(frame_bits(10)), 32'({1'b1, 8'h11, 1'b0}));
        check("tx 11 ready low", 32'(ready_low), 32'd160);
        check("reset no rx_valid", 32'(rx_cnt - cnt0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
